// File: rtl/hamming_7_4_pkg.sv
// Shared Hamming(7,4) types, register map and syndrome/correction helpers.
// Codeword layout {d3,d2,d1,p2,d0,p1,p0}; used by both rx and tx sides.
package hamming_7_4_pkg;

  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h1;
  localparam logic [3:0] ADDR_DATA   = 4'h2;
  localparam logic [3:0] ADDR_CORR   = 4'h3;
  localparam logic [3:0] ADDR_FRAME  = 4'h4;

  localparam int ENTRY_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    PUSH
  } rx_state_e;

  function automatic logic [2:0] calc_syndrome(
    input logic [6:0] cw
  );
    return {cw[3] ^ cw[4] ^ cw[5] ^ cw[6],
            cw[1] ^ cw[2] ^ cw[5] ^ cw[6],
            cw[0] ^ cw[2] ^ cw[4] ^ cw[6]};
  endfunction

  // A nonzero syndrome names the 1-based position of the bad bit.
  function automatic logic [6:0] correct_codeword(
    input logic [6:0] cw,
    input logic [2:0] syn
  );
    logic [6:0] flip;
    flip = (syn == 3'd0) ? 7'd0
                         : (7'd1 << (syn - 3'd1));
    return cw ^ flip;
  endfunction

endpackage

// File: rtl/hamming_7_4_serial_rx_if.sv
// CPU register bus for the Hamming(7,4) receiver.
// address/data_write/data_read/data_in from CPU, data_out back.
interface hamming_7_4_serial_rx_if;

  logic [3:0] address;
  logic       data_write;
  logic       data_read;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport master (
    output address,
    output data_write,
    output data_read,
    output data_in,
    input  data_out
  );

  modport slave (
    input  address,
    input  data_write,
    input  data_read,
    input  data_in,
    output data_out
  );

endinterface

// File: rtl/hamming_7_4_rx_fifo.sv
// Synchronous receive FIFO with push/pop/flush and level output.
// Ports: clk, rst, push, pop, flush, wdata -> head, full, empty, level.
module hamming_7_4_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign level = cnt;
  assign head  = mem[rp];

  // A full FIFO still accepts a push if a pop frees the slot.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(do_push)
                 - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst)
      mem[wp] <= wdata;
  end

endmodule

// File: rtl/hamming_7_4_serial_rx.sv
// Serial Hamming(7,4) receiver: deserialise, correct, queue for CPU.
// Ports: clk, rst, ui_in (din/bclk/frame_n), uo_out (irq/ovf), bus.
module hamming_7_4_serial_rx #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              ui_in,
  output logic [7:0]              uo_out,
  hamming_7_4_serial_rx_if.slave  bus
);

  import hamming_7_4_pkg::*;

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [2:0]         sync_q [SYNC_STAGES];
  logic               bclk_q;
  logic               din;
  logic               bclk;
  logic               frame_n;
  logic               bit_edge;

  rx_state_e          state;
  logic [2:0]         bitcnt;
  logic [6:0]         sr;
  logic               enable;
  logic               overflow;
  logic [7:0]         corr_cnt;
  logic [7:0]         frame_cnt;

  logic               wr_ctrl;
  logic               flush;
  logic               pop_req;
  logic               push_req;
  logic [2:0]         syn;
  logic [6:0]         fixed;
  logic [ENTRY_W-1:0] entry;
  logic [ENTRY_W-1:0] head;
  logic               full;
  logic               empty;
  logic [LW-1:0]      level;
  logic               unused_ok;

  assign unused_ok = ^{ui_in[7:3], bus.data_in[7:2]};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
      bclk_q <= 1'b0;
    end else begin
      sync_q[0] <= ui_in[2:0];
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
      bclk_q <= sync_q[SYNC_STAGES-1][1];
    end
  end

  assign din      = sync_q[SYNC_STAGES-1][0];
  assign bclk     = sync_q[SYNC_STAGES-1][1];
  assign frame_n  = sync_q[SYNC_STAGES-1][2];
  assign bit_edge = bclk & ~bclk_q;

  assign wr_ctrl  = bus.data_write
                  && bus.address == ADDR_CTRL;
  assign flush    = wr_ctrl & bus.data_in[1];
  assign pop_req  = bus.data_read
                  && bus.address == ADDR_DATA;
  assign push_req = (state == PUSH);

  assign syn   = calc_syndrome(sr);
  assign fixed = correct_codeword(sr, syn);
  assign entry = {1'b0, syn,
                  fixed[6], fixed[5],
                  fixed[4], fixed[2]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      bitcnt <= '0;
      sr     <= '0;
      enable <= 1'b0;
    end else begin
      if (wr_ctrl) enable <= bus.data_in[0];
      unique case (state)
        IDLE: begin
          if (enable && !frame_n) begin
            state  <= RECV;
            bitcnt <= '0;
          end
        end
        RECV: begin
          if (!enable || frame_n) begin
            state  <= IDLE;
            bitcnt <= '0;
          end else if (bit_edge) begin
            sr[bitcnt] <= din;
            bitcnt     <= bitcnt + 3'd1;
            if (bitcnt == 3'd6) state <= PUSH;
          end
        end
        PUSH: begin
          bitcnt <= '0;
          state  <= (enable && !frame_n)
                  ? RECV : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      corr_cnt  <= '0;
      frame_cnt <= '0;
    end else begin
      if (flush)
        overflow <= 1'b0;
      else if (push_req && full && !pop_req)
        overflow <= 1'b1;

      if (bus.data_write && bus.address == ADDR_CORR)
        corr_cnt <= '0;
      else if (push_req && syn != 3'd0
               && corr_cnt != 8'hFF)
        corr_cnt <= corr_cnt + 8'd1;

      if (bus.data_write && bus.address == ADDR_FRAME)
        frame_cnt <= '0;
      else if (push_req)
        frame_cnt <= frame_cnt + 8'd1;
    end
  end

  hamming_7_4_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop_req),
    .flush (flush),
    .wdata (entry),
    .head  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign uo_out = {6'd0, overflow, ~empty};

  always_comb begin
    bus.data_out = '0;
    case (bus.address)
      ADDR_CTRL:   bus.data_out = {7'd0, enable};
      ADDR_STATUS: bus.data_out = {4'(level),
                                   state != IDLE,
                                   overflow, full, empty};
      ADDR_DATA:   bus.data_out = empty ? '0 : head;
      ADDR_CORR:   bus.data_out = corr_cnt;
      ADDR_FRAME:  bus.data_out = frame_cnt;
      default:     bus.data_out = '0;
    endcase
  end

endmodule
